// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shift/add-subtract datapath runs 32 radix-2 steps per op on operand
// magnitudes, then a FIX cycle applies signs and selects the result word.
// Divide-by-zero and signed overflow skip the datapath through SPEC.
//
// Handshake: start is a request qualified by !cancel and sampled only in IDLE.
// stallreq holds the pipeline from the accepting cycle until the cycle before
// done. done is a one-cycle pulse, and result stays valid until the next done.
// rdy=0 freezes every register, and cancel returns any busy state to IDLE.
// dbg_state exposes the FSM state: 0 IDLE, 1 CALC, 2 FIX, 3 SPEC, 4 DONE.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            cancel,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            stallreq,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_SPEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;      // product or quotient must be negated
    logic              neg_rem_q;  // remainder takes the dividend's sign
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              done_q;

    // Operand decode for the incoming op: signedness, magnitudes, corner cases
    logic            signed_a, signed_b, sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_val;

    always_comb begin
        signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = signed_a & opa[XLEN-1];
        sb       = signed_b & opb[XLEN-1];
        abs_a    = sa ? -opa : opa;
        abs_b    = sb ? -opb : opb;
        div_zero = op[2] && (opb == '0);
        div_ovf  = op[2] && !op[0] && (opa == MIN_NEG) && (opb == ALL_ONES);
        special  = div_zero || div_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        spec_val = '0;
        if (div_zero) begin
            spec_val = op[1] ? opa : ALL_ONES;
        end else if (div_ovf) begin
            spec_val = op[1] ? '0 : MIN_NEG;
        end
    end

    // One radix-2 step: shift-add multiply and restoring divide
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_rem;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // Partial remainder shifted left by one with the next dividend bit;
        // the difference always fits XLEN bits when the subtract succeeds.
        div_rem  = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = div_rem >= {1'b0, b_q};
        div_diff = div_rem[XLEN-1:0] - b_q;
        div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                          : {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Sign correction and result word selection for the FIX cycle
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quot_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    // Control FSM and datapath registers; rdy gates every update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else if (rdy) begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel) begin
                        op_q      <= op;
                        b_q       <= abs_b;
                        neg_q     <= sa ^ sb;
                        neg_rem_q <= sa;
                        cnt_q     <= '0;
                        if (special) begin
                            acc_q   <= {{XLEN{1'b0}}, spec_val};
                            state_q <= S_SPEC;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, abs_a};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= op_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= fix_val;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_SPEC: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= acc_q[XLEN-1:0];
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall request covers acceptance through the last busy cycle
    always_comb begin
        stallreq = ((state_q == S_IDLE) && start && !cancel) ||
                   (state_q == S_CALC) || (state_q == S_FIX) || (state_q == S_SPEC);
    end

    assign result    = result_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
